// File: rtl/reg8_serial_reader.sv
// Serial readout of a parallel register value: start bit, data LSB-first, stop bit,
// each bit held for DIV clock cycles, with busy/ready status and a done pulse.
module reg8_serial_reader #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             busy,
    output logic             sdo,
    output logic             done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             sdo_q, sdo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_end_s;
    logic [WIDTH-1:0] sh_shift_s;

    assign bit_end_s  = (cnt_q == CNT_LAST);
    assign sh_shift_s = sh_q >> 1'b1;

    // State register and registered outputs; reset aborts any frame without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            sdo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; the bit-time counter wraps at the end of every bit
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end_s ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                sdo_d  = 1'b1;
                busy_d = 1'b0;
                if (en) begin
                    state_d = S_START;
                    sh_d    = d;
                    sdo_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    sdo_d   = sh_q[0];
                end else begin
                    state_d = S_START;
                end
            end

            S_DATA: begin
                if (bit_end_s) begin
                    sh_d = sh_shift_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        sdo_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = idx_q + IW'(1);
                        sdo_d   = sh_shift_s[0];
                    end
                end else begin
                    state_d = S_DATA;
                end
            end

            S_STOP: begin
                if (bit_end_s) begin
                    // ready rises with this edge, so a load is only taken on the done cycle
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sdo_d   = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                sdo_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ready = ~busy_q;
    assign busy  = busy_q;
    assign sdo   = sdo_q;
    assign done  = done_q;

endmodule

// File: tb/tb_reg8_serial_reader.sv
// Bench for reg8_serial_reader: DIV=4 and DIV=1 instances checked every cycle against a
// frame-position model, plus literal frame expectations for the directed scenarios.
module tb_reg8_serial_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, en1 = 1'b0;
    logic [7:0] d = 8'h00, d1 = 8'h00;
    logic       ready, busy, sdo, done;
    logic       ready1, busy1, sdo1, done1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg8_serial_reader #(.WIDTH(8), .DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .ready(ready), .busy(busy), .sdo(sdo), .done(done)
    );

    reg8_serial_reader #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .d(d1),
        .ready(ready1), .busy(busy1), .sdo(sdo1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line level k edges after the capture edge: slot 0 start, slots 1..8 data, then stop
    function automatic logic exp_sdo(input int k, input logic [7:0] dat, input int div);
        int slot;
        slot = k / div;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return dat[slot-1];
        else return 1'b1;
    endfunction

    // Model state: whether a frame runs, edges since capture, captured data, done pulse
    logic       m0_active, m0_done, m1_active, m1_done;
    int         m0_k, m1_k;
    logic [7:0] m0_data, m1_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_active <= 1'b0; m0_done <= 1'b0; m0_k <= 0; m0_data <= 8'h00;
        end else if (m0_active) begin
            m0_done   <= (m0_k + 1 == 40);
            m0_active <= (m0_k + 1 != 40);
            m0_k      <= m0_k + 1;
        end else begin
            m0_done <= 1'b0;
            if (en) begin
                m0_active <= 1'b1; m0_k <= 0; m0_data <= d;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_active <= 1'b0; m1_done <= 1'b0; m1_k <= 0; m1_data <= 8'h00;
        end else if (m1_active) begin
            m1_done   <= (m1_k + 1 == 10);
            m1_active <= (m1_k + 1 != 10);
            m1_k      <= m1_k + 1;
        end else begin
            m1_done <= 1'b0;
            if (en1) begin
                m1_active <= 1'b1; m1_k <= 0; m1_data <= d1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m0_active});
        chk("ready", {31'd0, ready}, {31'd0, ~m0_active});
        chk("done", {31'd0, done}, {31'd0, m0_done});
        chk("sdo", {31'd0, sdo}, {31'd0, m0_active ? exp_sdo(m0_k, m0_data, 4) : 1'b1});
        chk("busy1", {31'd0, busy1}, {31'd0, m1_active});
        chk("ready1", {31'd0, ready1}, {31'd0, ~m1_active});
        chk("done1", {31'd0, done1}, {31'd0, m1_done});
        chk("sdo1", {31'd0, sdo1}, {31'd0, m1_active ? exp_sdo(m1_k, m1_data, 1) : 1'b1});
    end

    // Called at a negedge: requests a load, returns at the negedge right after the capture edge
    task automatic load(input logic [7:0] val);
        en = 1'b1;
        d  = val;
        @(negedge clk);
        en = 1'b0;
        d  = 8'($urandom);
    endtask

    // Walks one DIV=4 frame from capture (k=0) to the done cycle (k=40)
    task automatic watch(input string tag, input logic [0:9] bits, input bit inject,
                         input bit chain, input logic [7:0] chain_d);
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (inject && k == 9) begin en = 1'b1; d = 8'hFF; end
            if (inject && k == 10) en = 1'b0;
            if (k < 40) begin
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_done"}, {31'd0, done}, 32'd0);
                if (k % 4 == 2) chk({tag, "_bit"}, {31'd0, sdo}, {31'd0, bits[k/4]});
            end else begin
                chk({tag, "_end_done"}, {31'd0, done}, 32'd1);
                chk({tag, "_end_ready"}, {31'd0, ready}, 32'd1);
                chk({tag, "_end_sdo"}, {31'd0, sdo}, 32'd1);
                if (chain) begin en = 1'b1; d = chain_d; end
            end
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_sdo", {31'd0, sdo}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_done", {31'd0, done}, 32'd0);

        load(8'hA5);
        watch("a5", 10'b0101001011, 1'b1, 1'b0, 8'h00);
        repeat (6) begin
            @(negedge clk);
            chk("no_second_frame", {31'd0, busy}, 32'd0);
        end

        load(8'h3C);
        watch("3c", 10'b0001111001, 1'b0, 1'b1, 8'hC3);
        @(negedge clk);
        en = 1'b0;
        d  = 8'h00;
        chk("b2b_sdo", {31'd0, sdo}, 32'd0);
        chk("b2b_done_fell", {31'd0, done}, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k < 40 && k % 4 == 2) chk("c3_bit", {31'd0, sdo}, {31'd0, 1'(10'b0110000111 >> (9 - k/4))});
            if (k == 40) chk("c3_end_done", {31'd0, done}, 32'd1);
        end

        @(negedge clk);
        load(8'h5A);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_sdo", {31'd0, sdo}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, done}, 32'd0);
        end
        load(8'h01);
        watch("01", 10'b0100000001, 1'b0, 1'b0, 8'h00);

        @(negedge clk);
        en1 = 1'b1;
        d1  = 8'h80;
        @(negedge clk);
        en1 = 1'b0;
        d1  = 8'h00;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 10) chk("div1_bit", {31'd0, sdo1}, {31'd0, 1'(10'b0000000011 >> (9 - k))});
            chk("div1_done", {31'd0, done1}, {31'd0, k == 10});
        end

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) == 0);
            d   = 8'($urandom);
            en1 = ($urandom_range(0, 2) == 0);
            d1  = 8'($urandom);
        end
        @(negedge clk);
        en  = 1'b0;
        en1 = 1'b0;
        repeat (45) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
